// File: rtl/frogger_game_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : frogger_game_ctrl
// Description : Game sequencer for the 8x8 Frogger display. Scrolls six
//               traffic lanes, merges them with the frog bitmap, detects
//               collisions and goal arrival, tracks lives and score, and
//               drives the composed display rows including the HIT, WIN
//               and OVER animations.
// Revision    : 1.0 - initial release
// ============================================================================
module frogger_game_ctrl #(
  parameter int SCROLL_DIV = 12500000,
  parameter int BLINK_DIV  = 6250000,
  parameter int LIVES      = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       move_tick,
  input  logic [7:0] frog_0,
  input  logic [7:0] frog_1,
  input  logic [7:0] frog_2,
  input  logic [7:0] frog_3,
  input  logic [7:0] frog_4,
  input  logic [7:0] frog_5,
  input  logic [7:0] frog_6,
  input  logic [7:0] frog_7,
  output logic       frog_reset,
  output logic [7:0] fila_0,
  output logic [7:0] fila_1,
  output logic [7:0] fila_2,
  output logic [7:0] fila_3,
  output logic [7:0] fila_4,
  output logic [7:0] fila_5,
  output logic [7:0] fila_6,
  output logic [7:0] fila_7,
  output logic [1:0] lives,
  output logic [3:0] score,
  output logic [2:0] state
);

  localparam int SCW = (SCROLL_DIV > 1) ? $clog2(SCROLL_DIV) : 1;
  localparam int BCW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
  localparam logic [SCW-1:0] SCROLL_LAST = SCW'(SCROLL_DIV - 1);
  localparam logic [BCW-1:0] BLINK_LAST  = BCW'(BLINK_DIV - 1);
  localparam logic [1:0]     LIVES_INIT  = 2'(LIVES);
  localparam logic [7:0]     LANE_INIT [1:6] = '{8'hC0, 8'h18, 8'h88, 8'h60, 8'h03, 8'h90};

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PLAY = 3'd1,
    S_HIT  = 3'd2,
    S_WIN  = 3'd3,
    S_OVER = 3'd4
  } state_t;

  state_t         cur_state, nxt_state;
  logic [7:0]     lane      [1:6];
  logic [7:0]     lane_row  [0:7];
  logic [7:0]     frog      [0:7];
  logic [7:0]     frame_nxt [0:7];
  logic [7:0]     frame     [0:7];
  logic [SCW-1:0] scroll_cnt;
  logic [BCW-1:0] blink_cnt;
  logic [1:0]     phase;
  logic           scroll_tick;
  logic           anim_last;
  logic           hit;
  logic           goal;

  assign frog = '{frog_0, frog_1, frog_2, frog_3, frog_4, frog_5, frog_6, frog_7};

  assign scroll_tick = (cur_state == S_PLAY) && (scroll_cnt == SCROLL_LAST);
  // Last cycle of the fourth half-phase (A,B,A,B) of an animation.
  assign anim_last   = (phase == 2'd3) && (blink_cnt == BLINK_LAST);
  assign goal        = |frog_0;

  // Full 8-row lane view; the goal row and the start row never carry traffic.
  always_comb begin
    lane_row[0] = 8'h00;
    lane_row[7] = 8'h00;
    for (int i = 1; i <= 6; i++) lane_row[i] = lane[i];
  end

  // Collision: any frog pixel sitting on a lane pixel in the same row.
  always_comb begin
    hit = 1'b0;
    for (int i = 0; i < 8; i++) hit = hit | (|(frog[i] & lane_row[i]));
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) cur_state <= S_IDLE;
    else       cur_state <= nxt_state;
  end

  // Next-state logic; a collision outranks reaching the goal.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      S_IDLE: if (move_tick) nxt_state = S_PLAY;
      S_PLAY: begin
        if (hit)       nxt_state = S_HIT;
        else if (goal) nxt_state = S_WIN;
      end
      S_HIT:  if (anim_last) nxt_state = (lives == 2'd1) ? S_OVER : S_PLAY;
      S_WIN:  if (anim_last) nxt_state = S_PLAY;
      S_OVER: if (move_tick) nxt_state = S_IDLE;
      default: nxt_state = S_IDLE;
    endcase
  end

  // Scroll timer: runs only in PLAY, restarts when a new game begins.
  always_ff @(posedge clk) begin
    if (reset)                                           scroll_cnt <= '0;
    else if (cur_state == S_IDLE && nxt_state == S_PLAY) scroll_cnt <= '0;
    else if (scroll_tick)                                scroll_cnt <= '0;
    else if (cur_state == S_PLAY)                        scroll_cnt <= scroll_cnt + 1'b1;
  end

  // Lane contents: odd lanes rotate left, even lanes rotate right.
  always_ff @(posedge clk) begin
    if (reset || (cur_state == S_OVER && move_tick)) begin
      for (int i = 1; i <= 6; i++) lane[i] <= LANE_INIT[i];
    end else if (scroll_tick) begin
      for (int i = 1; i <= 6; i++) begin
        if (i % 2 == 1) lane[i] <= {lane[i][6:0], lane[i][7]};
        else            lane[i] <= {lane[i][0], lane[i][7:1]};
      end
    end
  end

  // Animation timer: half-phase counter plus phase index, idle outside HIT/WIN.
  always_ff @(posedge clk) begin
    if (reset || !(cur_state == S_HIT || cur_state == S_WIN)) begin
      blink_cnt <= '0;
      phase     <= 2'd0;
    end else if (blink_cnt == BLINK_LAST) begin
      blink_cnt <= '0;
      phase     <= phase + 2'd1;
    end else begin
      blink_cnt <= blink_cnt + 1'b1;
    end
  end

  // Lives, score and frog-return pulse, applied when an animation completes.
  always_ff @(posedge clk) begin
    if (reset) begin
      lives      <= LIVES_INIT;
      score      <= 4'd0;
      frog_reset <= 1'b0;
    end else begin
      frog_reset <= 1'b0;
      if (cur_state == S_HIT && anim_last) begin
        lives      <= lives - 2'd1;
        frog_reset <= 1'b1;
      end
      if (cur_state == S_WIN && anim_last) begin
        if (score != 4'd15) score <= score + 4'd1;
        frog_reset <= 1'b1;
      end
      if (cur_state == S_OVER && move_tick) begin
        lives <= LIVES_INIT;
        score <= 4'd0;
      end
    end
  end

  // Frame composition for the current state and animation phase.
  always_comb begin
    for (int i = 0; i < 8; i++) begin
      frame_nxt[i] = lane_row[i] | frog[i];
      case (cur_state)
        S_HIT:  frame_nxt[i] = phase[0] ? lane_row[i] : 8'hFF;
        S_WIN:  if (!phase[0]) frame_nxt[i] = (i == 0) ? 8'hFF : 8'h00;
        S_OVER: frame_nxt[i] = (8'h01 << i) | (8'h80 >> i);
        default: ;
      endcase
    end
  end

  // Registered frame, one cycle behind lanes/frog/state.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) frame[i] <= 8'h00;
    end else begin
      for (int i = 0; i < 8; i++) frame[i] <= frame_nxt[i];
    end
  end

  assign fila_0 = frame[0];
  assign fila_1 = frame[1];
  assign fila_2 = frame[2];
  assign fila_3 = frame[3];
  assign fila_4 = frame[4];
  assign fila_5 = frame[5];
  assign fila_6 = frame[6];
  assign fila_7 = frame[7];
  assign state  = cur_state;

endmodule
`default_nettype wire
